// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parameterised FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // Read-side behaviour: registered pop or first-word-fall-through.
    typedef enum logic {
        RD_STANDARD = 1'b0,
        RD_FWFT     = 1'b1
    } read_mode_e;

    // Address width for a power-of-two depth; occupancy needs one bit more.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the write word; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with registered flags and sticky errors.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          DATA_IN,
    input  logic                      WR_EN,
    input  logic                      RD_EN,
    input  logic                      CLR_ERR,
    output logic [WIDTH-1:0]          DATA_OUT,
    output logic                      EMPTY,
    output logic                      FULL,
    output logic                      ALMOST_FULL,
    output logic                      ALMOST_EMPTY,
    output logic [ptr_width(DEPTH):0] COUNT,
    output logic                      OVERFLOW,
    output logic                      UNDERFLOW
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam read_mode_e       MODE     = (FWFT != 0) ? RD_FWFT : RD_STANDARD;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0]    CNT_AE   = CW'(AE_LEVEL);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    ram_rd_addr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] ram_rd_data;
    logic [WIDTH-1:0] head_word;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance is judged against the registered flags of this cycle.
    assign wr_ok = WR_EN && !FULL;
    assign rd_ok = RD_EN && !EMPTY;

    // Next read pointer and next occupancy.
    always_comb begin
        rd_ptr_nxt = rd_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
        count_nxt  = COUNT;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = COUNT + CNT_ONE;
            2'b01:   count_nxt = COUNT - CNT_ONE;
            default: count_nxt = COUNT;
        endcase
    end

    // FWFT looks one pop ahead; standard mode reads the current head.
    assign ram_rd_addr = (MODE == RD_FWFT) ? rd_ptr_nxt : rd_ptr;

    // The next head can be the word being written right now (fifo empty after
    // any pop), which the RAM cannot show yet, so bypass DATA_IN for it.
    always_comb begin
        head_word = ram_rd_data;
        if (wr_ok && (wr_ptr == rd_ptr_nxt)) begin
            head_word = DATA_IN;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (DATA_IN),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Pointer and occupancy registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            COUNT  <= count_nxt;
        end
    end

    // Status flags registered from the next-state occupancy.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            EMPTY        <= (count_nxt == '0);
            FULL         <= (count_nxt == CNT_FULL);
            ALMOST_FULL  <= (count_nxt >= CNT_AF);
            ALMOST_EMPTY <= (count_nxt <= CNT_AE);
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end
            if (RD_EN && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                UNDERFLOW <= 1'b0;
            end
        end
    end

    // Output data register: load on pop, or track the head in FWFT mode.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            DATA_OUT <= '0;
        end else if (MODE == RD_FWFT) begin
            if (count_nxt != '0) begin
                DATA_OUT <= head_word;
            end
        end else if (rd_ok) begin
            DATA_OUT <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param in standard and first-word-fall-through modes.
module tb_fifo_param;

    logic       clk = 1'b0;

    logic       a_rst = 1'b0, a_wr = 1'b0, a_rd = 1'b0, a_clr = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_empty, a_full, a_af, a_ae, a_ov, a_un;
    logic [4:0] a_cnt;

    logic       b_rst = 1'b0, b_wr = 1'b0, b_rd = 1'b0, b_clr = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_empty, b_full, b_af, b_ae, b_ov, b_un;
    logic [4:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut_std (
        .CLK(clk), .RST(a_rst), .DATA_IN(a_din), .WR_EN(a_wr), .RD_EN(a_rd),
        .CLR_ERR(a_clr), .DATA_OUT(a_dout), .EMPTY(a_empty), .FULL(a_full),
        .ALMOST_FULL(a_af), .ALMOST_EMPTY(a_ae), .COUNT(a_cnt),
        .OVERFLOW(a_ov), .UNDERFLOW(a_un)
    );

    fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fwft (
        .CLK(clk), .RST(b_rst), .DATA_IN(b_din), .WR_EN(b_wr), .RD_EN(b_rd),
        .CLR_ERR(b_clr), .DATA_OUT(b_dout), .EMPTY(b_empty), .FULL(b_full),
        .ALMOST_FULL(b_af), .ALMOST_EMPTY(b_ae), .COUNT(b_cnt),
        .OVERFLOW(b_ov), .UNDERFLOW(b_un)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_push(input logic [7:0] d);
        a_wr = 1'b1; a_din = d;
        step();
        a_wr = 1'b0;
    endtask

    task automatic a_pop();
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
    endtask

    initial begin
        // reset both instances
        #1;
        step();
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_aempty", 32'(a_ae), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_afull", 32'(a_af), 0);
        chk("rst_ovf", 32'(a_ov), 0);
        chk("rst_unf", 32'(a_un), 0);
        chk("rst_dout", 32'(a_dout), 0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // fill to 15 then 16
        for (int i = 0; i < 15; i++) a_push(8'(8'h11 + i));
        chk("fill15_count", 32'(a_cnt), 15);
        chk("fill15_afull", 32'(a_af), 1);
        chk("fill15_full", 32'(a_full), 0);
        a_push(8'h20);
        chk("fill16_full", 32'(a_full), 1);
        chk("fill16_count", 32'(a_cnt), 16);

        // overflow, set-over-clear, clear
        a_push(8'hAA);
        chk("ovf_set", 32'(a_ov), 1);
        chk("ovf_count", 32'(a_cnt), 16);
        a_wr = 1'b1; a_din = 8'hAA; a_clr = 1'b1;
        step();
        chk("ovf_set_wins", 32'(a_ov), 1);
        a_wr = 1'b0;
        step();
        chk("ovf_clear", 32'(a_ov), 0);
        a_clr = 1'b0;

        // drain 16 in order, almost-empty boundary
        for (int i = 0; i < 16; i++) begin
            a_pop();
            chk("drain1_data", 32'(a_dout), (i < 15) ? (32'h11 + 32'(i)) : 32'h20);
            if (i == 12) chk("drain1_ae_cnt3", 32'(a_ae), 0);
            if (i == 13) chk("drain1_ae_cnt2", 32'(a_ae), 1);
        end
        chk("drain1_empty", 32'(a_empty), 1);
        chk("drain1_count", 32'(a_cnt), 0);

        // underflow
        a_pop();
        chk("unf_set", 32'(a_un), 1);
        chk("unf_dout_hold", 32'(a_dout), 32'h20);
        chk("unf_count", 32'(a_cnt), 0);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        chk("unf_clear", 32'(a_un), 0);

        // wrap-around: fill 16, drain 10, write 10, full write+read, drain rest
        for (int i = 0; i < 16; i++) a_push(8'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            a_pop();
            chk("wrap_drain10", 32'(a_dout), 32'h30 + 32'(i));
        end
        for (int i = 0; i < 10; i++) a_push(8'(8'h40 + i));
        chk("wrap_full", 32'(a_full), 1);
        a_wr = 1'b1; a_rd = 1'b1; a_din = 8'hBB;
        step();
        a_wr = 1'b0; a_rd = 1'b0;
        chk("full_wr_rd_data", 32'(a_dout), 32'h3A);
        chk("full_wr_rd_count", 32'(a_cnt), 15);
        chk("full_wr_rd_ovf", 32'(a_ov), 1);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            a_pop();
            chk("wrap_drain_rest", 32'(a_dout), (i < 5) ? (32'h3B + 32'(i)) : (32'h40 + 32'(i - 5)));
        end
        chk("wrap_empty", 32'(a_empty), 1);
        chk("wrap_aempty", 32'(a_ae), 1);
        chk("wrap_count", 32'(a_cnt), 0);

        // steady state: count 5, simultaneous push/pop
        for (int i = 0; i < 5; i++) a_push(8'(8'h50 + i));
        chk("ss_count_init", 32'(a_cnt), 5);
        a_wr = 1'b1; a_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_din = 8'(8'h55 + i);
            step();
            chk("ss_data", 32'(a_dout), 32'h50 + 32'(i));
            chk("ss_count", 32'(a_cnt), 5);
        end
        a_wr = 1'b0; a_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_pop();
            chk("ss_drain", 32'(a_dout), 32'h58 + 32'(i));
        end
        chk("ss_empty", 32'(a_empty), 1);

        // first-word-fall-through instance
        chk("fwft_idle_empty", 32'(b_empty), 1);
        b_wr = 1'b1; b_din = 8'h42;
        step();
        b_wr = 1'b0;
        chk("fwft_first_data", 32'(b_dout), 32'h42);
        chk("fwft_first_empty", 32'(b_empty), 0);
        chk("fwft_first_count", 32'(b_cnt), 1);
        step();
        chk("fwft_hold_data", 32'(b_dout), 32'h42);
        b_wr = 1'b1; b_din = 8'h43;
        step();
        b_din = 8'h44;
        step();
        b_wr = 1'b0;
        chk("fwft_head_stays", 32'(b_dout), 32'h42);
        chk("fwft_count3", 32'(b_cnt), 3);
        b_rd = 1'b1;
        step();
        chk("fwft_pop_data", 32'(b_dout), 32'h43);
        chk("fwft_pop_count", 32'(b_cnt), 2);
        b_wr = 1'b1; b_din = 8'h45;
        step();
        chk("fwft_wr_rd_data", 32'(b_dout), 32'h44);
        chk("fwft_wr_rd_count", 32'(b_cnt), 2);

        // reset mid-stream overrides requests
        b_rst = 1'b0;
        step();
        b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0;
        chk("fwft_rst_count", 32'(b_cnt), 0);
        chk("fwft_rst_empty", 32'(b_empty), 1);
        chk("fwft_rst_aempty", 32'(b_ae), 1);
        chk("fwft_rst_full", 32'(b_full), 0);
        chk("fwft_rst_afull", 32'(b_af), 0);
        chk("fwft_rst_ovf", 32'(b_ov), 0);
        chk("fwft_rst_unf", 32'(b_un), 0);
        chk("fwft_rst_dout", 32'(b_dout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which ALMOST_FULL asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which ALMOST_EMPTY asserts.
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 = standard registered read, 1 = first-word-fall-through).
REQ-006 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port DATA_IN  input  WIDTH  write data.
REQ-009 SHALL have port WR_EN  input  1  write request.
REQ-010 SHALL have port RD_EN  input  1  read request (pop).
REQ-011 SHALL have port CLR_ERR  input  1  clears sticky OVERFLOW/UNDERFLOW.
REQ-012 SHALL have port DATA_OUT  output  WIDTH  read data.
REQ-013 SHALL have port EMPTY  output  1  occupancy == 0.
REQ-014 SHALL have port FULL  output  1  occupancy == DEPTH.
REQ-015 SHALL have port ALMOST_FULL  output  1  occupancy >= AF_LEVEL.
REQ-016 SHALL have port ALMOST_EMPTY  output  1  occupancy <= AE_LEVEL.
REQ-017 SHALL have port COUNT  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have port OVERFLOW  output  1  sticky: write attempted while FULL.
REQ-019 SHALL have port UNDERFLOW  output  1  sticky: read attempted while EMPTY.

Function
REQ-020 Write SHALL be accepted when WR_EN=1 and FULL=0; DATA_IN stored at write pointer, pointer +1 modulo DEPTH.
REQ-021 Read SHALL be accepted when RD_EN=1 and EMPTY=0; read pointer +1 modulo DEPTH.
REQ-022 WR_EN=1 with FULL=1 SHALL be dropped (no storage change) even if a read is accepted in the same cycle.
REQ-023 RD_EN=1 with EMPTY=1 SHALL be ignored; DATA_OUT unchanged.
REQ-024 Simultaneous accepted read and write SHALL leave COUNT unchanged; write only +1; read only -1.
REQ-025 All flags SHALL be registered, derived from the next-state COUNT, valid the cycle after the causing edge.
REQ-026 FWFT=0: DATA_OUT SHALL load the head word on the edge the read is accepted (1-cycle read latency) and hold otherwise.
REQ-027 FWFT=1: DATA_OUT SHALL present the head word whenever EMPTY=0; an accepted read advances to the next word; first write into an empty FIFO SHALL be visible on DATA_OUT the cycle after the write edge.
REQ-028 OVERFLOW/UNDERFLOW SHALL set on the rejected-request edge and hold until CLR_ERR=1; set SHALL win over clear in the same cycle.
REQ-029 Order SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-030 With RST=0 at a clock edge: pointers=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, DATA_OUT=0.
REQ-031 Reset SHALL override WR_EN/RD_EN in the same cycle; contents at reset are discarded (storage array itself not reset).

Structure
REQ-032 Shared package fifo_pkg SHALL hold default WIDTH/DEPTH constants and the pointer/count width helper function.
REQ-033 Storage SHALL be a sub-module fifo_ram (one synchronous write port, asynchronous read port); pointers, count, flags live in fifo_param.

Verification
REQ-034 Reset then write 0x11..0x1F (15 words), DEPTH=16 -> COUNT=15, ALMOST_FULL=1, FULL=0; one more write -> FULL=1, COUNT=16.
REQ-035 FULL, WR_EN=1 with DATA_IN=0xAA -> OVERFLOW=1, COUNT=16, 0xAA never read; CLR_ERR pulse -> OVERFLOW=0.
REQ-036 Empty, RD_EN=1 -> UNDERFLOW=1, DATA_OUT unchanged, COUNT=0.
REQ-037 Fill 16, drain 10, write 10 more (wrap), drain all -> data order exact, EMPTY=1, ALMOST_EMPTY=1 at end.
REQ-038 COUNT=5, WR_EN=RD_EN=1 for 8 cycles -> COUNT stays 5, outputs in write order.
REQ-039 FWFT=1: write 0x42 into empty FIFO -> DATA_OUT=0x42, EMPTY=0 next cycle with no RD_EN; RST=0 mid-stream -> all outputs at REQ-030 values next cycle.
